// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
// The PC_GEN_COMPRESSED_EN build selects the 16-bit alignment rule.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        REDIR,
        TRAP
    } pend_kind_t;

    // Low address bits that must be zero for a legal fetch target.
    localparam logic [1:0] ALIGN_LOW_STD = 2'b11;
    localparam logic [1:0] ALIGN_LOW_C   = 2'b01;

    function automatic logic [1:0] align_low(input logic compressed);
        return compressed ? ALIGN_LOW_C : ALIGN_LOW_STD;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect priority select (trap > redirect > pending > sequential) plus the pending-target register.
// Alignment rule follows PC_GEN_COMPRESSED_EN (bit0 only when defined, bits[1:0] otherwise).
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] seq_pc,
    input  logic            capture,
    input  logic            consume,
    output logic            event_valid,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign_evt
);

    logic [1:0]      low_mask;
    logic [XLEN-1:0] ev_raw;
    logic [XLEN-1:0] ev_pc;
    logic            ev_mis;
    logic            ev_load;
    logic            pend_write;
    pend_kind_t      ev_kind;
    pend_kind_t      pend_kind;
    logic [XLEN-1:0] pend_pc;

`ifdef PC_GEN_COMPRESSED_EN
    assign low_mask = align_low(1'b1);
`else
    assign low_mask = align_low(1'b0);
`endif

    always_comb begin
        event_valid = trap_valid | redirect_valid;
        ev_raw      = trap_valid ? trap_pc : redirect_pc;
        ev_kind     = trap_valid ? TRAP : REDIR;
        ev_pc       = ev_raw & ~{{(XLEN-2){1'b0}}, low_mask};
        ev_mis      = |(ev_raw[1:0] & low_mask);
        // A parked trap can only be displaced by a newer trap.
        pend_write  = capture && event_valid && ((pend_kind != TRAP) || trap_valid);
        ev_load     = event_valid && (!capture || pend_write);
        misalign_evt = ev_load && ev_mis;
        if (event_valid) begin
            next_pc = ev_pc;
        end else if (pend_kind != NONE) begin
            next_pc = pend_pc;
        end else begin
            next_pc = seq_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_kind <= NONE;
            pend_pc   <= '0;
        end else if (consume) begin
            pend_kind <= NONE;
        end else if (pend_write) begin
            pend_kind <= ev_kind;
            pend_pc   <= ev_pc;
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage PC generator: valid/ready fetch request with trap/branch redirects held across stalls.
// Optional 16-bit sequencing and bit0-only alignment under PC_GEN_COMPRESSED_EN.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP_BYTES   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            req_ready_i,
`ifdef PC_GEN_COMPRESSED_EN
    input  logic            seq_half_i,
`endif
    output logic            req_valid_o,
    output logic [XLEN-1:0] req_pc_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    state_t          state;
    state_t          next_state;
    logic            next_valid;
    logic            accept;
    logic            stalled_req;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] seq_pc;
    logic            event_valid;
    logic [XLEN-1:0] next_pc;
    logic            misalign_evt;

    assign accept      = req_valid_o && req_ready_i;
    assign stalled_req = req_valid_o && !req_ready_i;

`ifdef PC_GEN_COMPRESSED_EN
    assign step = seq_half_i ? XLEN'(2) : XLEN'(4);
`else
    assign step = XLEN'(STEP_BYTES);
`endif

    // Wraps modulo 2^XLEN by construction.
    assign seq_pc = req_pc_o + step;

    pc_redirect_arb #(
        .XLEN (XLEN)
    ) u_arb (
        .clk            (clk),
        .rst_n          (rst_n),
        .trap_valid     (trap_valid_i),
        .trap_pc        (trap_pc_i),
        .redirect_valid (redirect_valid_i),
        .redirect_pc    (redirect_pc_i),
        .seq_pc         (seq_pc),
        .capture        (stalled_req),
        .consume        (accept),
        .event_valid    (event_valid),
        .next_pc        (next_pc),
        .misalign_evt   (misalign_evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        next_valid = !stall_i || stalled_req;
        case (state)
            BOOT: begin
                next_state = RUN;
                next_valid = 1'b0;
            end
            RUN: begin
                if (stalled_req && event_valid) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
                next_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_o <= 1'b0;
            req_pc_o    <= RESET_VECTOR;
            pc_o        <= RESET_VECTOR;
            misalign_o  <= 1'b0;
        end else begin
            req_valid_o <= next_valid;
            misalign_o  <= misalign_evt;
            if (accept) begin
                pc_o     <= req_pc_o;
                req_pc_o <= next_pc;
            end else if (!req_valid_o && event_valid) begin
                // Nothing on the wire yet, so the target can be taken immediately.
                req_pc_o <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit with hand-computed expectations.
// Covers PC_GEN_COMPRESSED_EN when the macro is defined for the build.
module tb_pc_gen_unit;
    import pc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        trap_valid_i;
    logic [31:0] trap_pc_i;
    logic        req_ready_i;
    logic        seq_half_i;
    logic        req_valid_o;
    logic [31:0] req_pc_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    int n_checks;
    int n_errors;

    pc_gen_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_valid_i     (trap_valid_i),
        .trap_pc_i        (trap_pc_i),
        .req_ready_i      (req_ready_i),
`ifdef PC_GEN_COMPRESSED_EN
        .seq_half_i       (seq_half_i),
`endif
        .req_valid_o      (req_valid_o),
        .req_pc_o         (req_pc_o),
        .pc_o             (pc_o),
        .misalign_o       (misalign_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        redirect_valid_i = 1'b0;
        trap_valid_i     = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        rst_n            = 1'b0;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        trap_valid_i     = 1'b0;
        trap_pc_i        = '0;
        req_ready_i      = 1'b1;
        seq_half_i       = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_valid", 32'(req_valid_o), 32'd0);
        check_eq("rst_req_pc", req_pc_o, 32'h0);
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_misalign", 32'(misalign_o), 32'd0);
        check_eq("rst_state", 32'(dut.state), 32'(BOOT));
        rst_n = 1'b1;

        // Boot and sequential fetch
        tick();
        check_eq("boot_valid_c1", 32'(req_valid_o), 32'd0);
        check_eq("boot_state_c1", 32'(dut.state), 32'(RUN));
        tick();
        check_eq("boot_valid_c2", 32'(req_valid_o), 32'd1);
        check_eq("seq_req0", req_pc_o, 32'h0);
        tick();
        check_eq("seq_req4", req_pc_o, 32'h4);
        check_eq("seq_pc0", pc_o, 32'h0);
        tick();
        check_eq("seq_req8", req_pc_o, 32'h8);
        check_eq("seq_pc4", pc_o, 32'h4);

        // Redirect while the request is stalled for three cycles
        req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        clear_strobes();
        check_eq("hold_req_c1", req_pc_o, 32'h8);
        check_eq("hold_state", 32'(dut.state), 32'(HOLD));
        tick();
        tick();
        check_eq("hold_req_c3", req_pc_o, 32'h8);
        check_eq("hold_valid", 32'(req_valid_o), 32'd1);
        req_ready_i = 1'b1;
        tick();
        check_eq("pend_req", req_pc_o, 32'h100);
        check_eq("pend_pc", pc_o, 32'h8);
        check_eq("pend_state", 32'(dut.state), 32'(RUN));
        tick();
        check_eq("pend_seq", req_pc_o, 32'h104);

        // Trap and redirect in the same cycle
        trap_valid_i = 1'b1;
        trap_pc_i = 32'h80;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        clear_strobes();
        check_eq("both_req", req_pc_o, 32'h80);
        tick();
        check_eq("both_lost", req_pc_o, 32'h84);
        check_eq("both_pc", pc_o, 32'h80);

        // Pending trap survives a later redirect
        req_ready_i = 1'b0;
        trap_valid_i = 1'b1;
        trap_pc_i = 32'h80;
        tick();
        clear_strobes();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h300;
        tick();
        clear_strobes();
        check_eq("ptrap_held", req_pc_o, 32'h84);
        req_ready_i = 1'b1;
        tick();
        check_eq("ptrap_req", req_pc_o, 32'h80);
        check_eq("ptrap_pc", pc_o, 32'h84);
        check_eq("ptrap_nomis", 32'(misalign_o), 32'd0);

        // Misaligned target
        redirect_valid_i = 1'b1;
`ifdef PC_GEN_COMPRESSED_EN
        redirect_pc_i = 32'h103;
        tick();
        clear_strobes();
        check_eq("mis_req", req_pc_o, 32'h102);
        check_eq("mis_pulse", 32'(misalign_o), 32'd1);
        seq_half_i = 1'b1;
        tick();
        seq_half_i = 1'b0;
        check_eq("mis_clear", 32'(misalign_o), 32'd0);
        check_eq("half_step", req_pc_o, 32'h104);
`else
        redirect_pc_i = 32'h102;
        tick();
        clear_strobes();
        check_eq("mis_req", req_pc_o, 32'h100);
        check_eq("mis_pulse", 32'(misalign_o), 32'd1);
        tick();
        check_eq("mis_clear", 32'(misalign_o), 32'd0);
        check_eq("mis_seq", req_pc_o, 32'h104);
`endif

        // Idle redirect loads directly even while stalled
        stall_i = 1'b1;
        tick();
        check_eq("idle_valid", 32'(req_valid_o), 32'd0);
        check_eq("idle_req", req_pc_o, 32'h108);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        clear_strobes();
        check_eq("idle_load", req_pc_o, 32'h40);
        check_eq("idle_valid2", 32'(req_valid_o), 32'd0);
        tick();
        check_eq("idle_keep", req_pc_o, 32'h40);
        stall_i = 1'b0;
        tick();
        check_eq("idle_issue", 32'(req_valid_o), 32'd1);
        check_eq("idle_issue_pc", req_pc_o, 32'h40);

        // Address wrap
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        clear_strobes();
        check_eq("wrap_top", req_pc_o, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_zero", req_pc_o, 32'h0);
        check_eq("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check_eq("wrap_nomis", 32'(misalign_o), 32'd0);

        // Reset while holding a pending redirect
        req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h500;
        tick();
        clear_strobes();
        check_eq("rhold_state", 32'(dut.state), 32'(HOLD));
        rst_n = 1'b0;
        #1;
        check_eq("rhold_req", req_pc_o, 32'h0);
        check_eq("rhold_valid", 32'(req_valid_o), 32'd0);
        tick();
        rst_n = 1'b1;
        req_ready_i = 1'b1;
        tick();
        tick();
        check_eq("rhold_issue", req_pc_o, 32'h0);
        tick();
        check_eq("rhold_nopend", req_pc_o, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
